note_square_sequencer: RTL

Frame-level controller for the note-lane drawing datapath. On each frame tick it snapshots the red/yellow note sequences, then walks the NUM_SLOTS lane squares. For each square it rasterises a SQ_SIZE x SQ_SIZE block: first an erase pass in BLACK, then a draw pass in the note colour. Its plot/x/y/colour outputs drive the VGA adapter write port directly, at one pixel per cycle.

---
 rtl/note_square_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/note_square_sequencer.sv
// Frame-level sequencer: erases, then redraws, each note-lane square, one VGA pixel per cycle.
// Optional build macro NOTE_SEQ_DIRTY_SKIP_EN skips slots whose colour code is unchanged since the last frame.
module note_square_sequencer #(
  parameter int NUM_SLOTS  = 10,
  parameter int SLOT_PITCH = 10,
  parameter int X_BASE     = 10,
  parameter int Y_BASE     = 112,
  parameter int SQ_SIZE    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] red_sequence,
  input  logic [NUM_SLOTS-1:0] yellow_sequence,
  output logic                 busy,
  output logic                 done,
  output logic                 plot,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour
);

  localparam int CB = $clog2(SQ_SIZE);
  localparam int PB = 2 * CB;
  localparam int SB = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PB-1:0] PX_MAX    = '1;
  localparam logic [SB-1:0] SLOT_LAST = SB'(NUM_SLOTS - 1);
  localparam logic [7:0]    X_ORIGIN  = 8'(X_BASE);
  localparam logic [7:0]    X_STEP    = 8'(SLOT_PITCH);
  localparam logic [6:0]    Y_ORIGIN  = 7'(Y_BASE);
  localparam logic [2:0]    BLACK     = 3'b000;

  typedef enum logic [1:0] {C_NONE, C_RED, C_YELLOW} code_t;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ERASE, S_DRAW, S_DONE} state_t;

  function automatic logic [2:0] code_colour(code_t c);
    case (c)
      C_RED:    return 3'b100;
      C_YELLOW: return 3'b110;
      default:  return BLACK;
    endcase
  endfunction

  state_t               state;
  logic [SB-1:0]        slot;
  logic [PB-1:0]        px;
  logic [7:0]           slot_x;
  logic [NUM_SLOTS-1:0] red_snap;
  logic [NUM_SLOTS-1:0] yellow_snap;
  code_t                slot_code;
  logic [PB-1:0]        px_inc;

`ifdef NOTE_SEQ_DIRTY_SKIP_EN
  code_t prev_code [NUM_SLOTS];
`endif

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    slot_code = C_NONE;
    if (red_snap[slot])         slot_code = C_RED;
    else if (yellow_snap[slot]) slot_code = C_YELLOW;
  end

  assign px_inc = px + PB'(1);
  assign busy   = (state != S_IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      slot        <= '0;
      px          <= '0;
      slot_x      <= X_ORIGIN;
      red_snap    <= '0;
      yellow_snap <= '0;
      done        <= 1'b0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= BLACK;
`ifdef NOTE_SEQ_DIRTY_SKIP_EN
      // NOTE: the retained codes are a small register array, so clearing them on reset is cheap and required.
      for (int i = 0; i < NUM_SLOTS; i++) prev_code[i] <= C_NONE;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            red_snap    <= red_sequence;
            yellow_snap <= yellow_sequence;
            slot        <= '0;
            px          <= '0;
            slot_x      <= X_ORIGIN;
`ifdef NOTE_SEQ_DIRTY_SKIP_EN
            state       <= S_CHECK;
`else
            state       <= S_ERASE;
            plot        <= 1'b1;
            x           <= X_ORIGIN;
            y           <= Y_ORIGIN;
            colour      <= BLACK;
`endif
          end
        end

`ifdef NOTE_SEQ_DIRTY_SKIP_EN
        S_CHECK: begin
          if (slot_code != prev_code[slot]) begin
            prev_code[slot] <= slot_code;
            state           <= S_ERASE;
            px              <= '0;
            plot            <= 1'b1;
            x               <= slot_x;
            y               <= Y_ORIGIN;
            colour          <= BLACK;
          end else if (slot == SLOT_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            slot   <= slot + SB'(1);
            slot_x <= slot_x + X_STEP;
          end
        end
`endif

        S_ERASE, S_DRAW: begin
          if (px != PX_MAX) begin
            px <= px_inc;
            x  <= slot_x + 8'(px_inc[CB-1:0]);
            y  <= Y_ORIGIN + 7'(px_inc[PB-1:CB]);
          end else if (state == S_ERASE && slot_code != C_NONE) begin
            state  <= S_DRAW;
            px     <= '0;
            x      <= slot_x;
            y      <= Y_ORIGIN;
            colour <= code_colour(slot_code);
          end else if (slot == SLOT_LAST) begin
            state  <= S_DONE;
            done   <= 1'b1;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= BLACK;
          end else begin
            slot   <= slot + SB'(1);
            slot_x <= slot_x + X_STEP;
            px     <= '0;
`ifdef NOTE_SEQ_DIRTY_SKIP_EN
            state  <= S_CHECK;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= BLACK;
`else
            state  <= S_ERASE;
            x      <= slot_x + X_STEP;
            y      <= Y_ORIGIN;
            colour <= BLACK;
`endif
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
